nanocache_mem_sched: RTL

- Shares one main-memory line port (8x32-bit lines) between NUM_PE cache miss/write-back requesters.
- Round-robin arbitration; one memory transaction outstanding at a time.
- Holds each transaction until memory grants it, then routes read data back to the originating PE.
- Sits between the per-PE cache refill/write-back logic and the SRAM line interface.

---
 rtl/nanocache_mem_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/nanocache_mem_sched.sv
// nanocache_mem_sched: round-robin scheduler sharing one 8x32-bit main-memory line port among NUM_PE requesters.
// Optional read-wait watchdog (o_err) is compiled in with `define NANOCACHE_SCHED_TIMEOUT_EN.
module nanocache_mem_sched #(
    parameter int unsigned NUM_PE      = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_PE-1:0]                i_flush,
    input  logic [NUM_PE-1:0]                i_req_rden,
    input  logic [NUM_PE-1:0]                i_req_wren,
    input  logic [NUM_PE-1:0][31:0]          i_req_addr,
    input  logic [NUM_PE-1:0][7:0][31:0]     i_req_wdata,
    output logic [NUM_PE-1:0]                o_req_gnt,
    output logic [NUM_PE-1:0]                o_resp_valid,
    output logic [7:0][31:0]                 o_resp_rdata,
    output logic                             o_mm_rden,
    output logic                             o_mm_wren,
    output logic [31:0]                      o_mm_addr,
    output logic [7:0][31:0]                 o_mm_wdata,
    input  logic                             i_mm_gnt,
    input  logic [7:0][31:0]                 i_mm_rdata,
    input  logic                             i_mm_rvalid,
    output logic                             o_busy,
    output logic                             o_err
);

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned PTR_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t                                  state_q, state_d;
    logic [PTR_W-1:0]                        rr_q, rr_d;
    logic [PTR_W-1:0]                        win_q, win_d;
    logic                                    drop_q, drop_d;
    logic                                    mm_rden_d, mm_wren_d;
    logic [ADDR_W-1:0]                       mm_addr_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]       mm_wdata_d;
    logic [NUM_PE-1:0]                       resp_valid_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]       resp_rdata_d;

    logic [NUM_PE-1:0]                       cand;
    logic                                    arb_hit;
    logic [PTR_W-1:0]                        arb_idx;
    logic [NUM_PE-1:0]                       win_oh;
    logic [PTR_W-1:0]                        win_inc;
    logic                                    win_flush;

`ifdef NANOCACHE_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]                        cnt_q, cnt_d;
    logic                                    err_d;
`endif

    // Round-robin pick: first requester at or above rr_q, wrapping modulo NUM_PE
    always_comb begin : arb
        int unsigned      scan;
        logic [PTR_W-1:0] scan_ptr;
        cand    = i_req_rden | i_req_wren;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            scan = 32'(rr_q) + i;
            if (scan >= NUM_PE) begin
                scan = scan - NUM_PE;
            end
            scan_ptr = PTR_W'(scan);
            if (!arb_hit && cand[scan_ptr]) begin
                arb_hit = 1'b1;
                arb_idx = scan_ptr;
            end
        end
    end

    assign win_oh    = NUM_PE'(1) << win_q;
    assign win_inc   = (win_q == PTR_W'(NUM_PE - 1)) ? '0 : win_q + PTR_W'(1);
    assign win_flush = i_flush[win_q];
    assign o_req_gnt = ((state_q == ISSUE) && i_mm_gnt) ? win_oh : '0;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        win_d        = win_q;
        drop_d       = drop_q;
        mm_rden_d    = o_mm_rden;
        mm_wren_d    = o_mm_wren;
        mm_addr_d    = o_mm_addr;
        mm_wdata_d   = o_mm_wdata;
        resp_valid_d = '0;
        resp_rdata_d = o_resp_rdata;
`ifdef NANOCACHE_SCHED_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    // A PE with both strobes set gets its write-back served first
                    win_d      = arb_idx;
                    mm_wren_d  = i_req_wren[arb_idx];
                    mm_rden_d  = ~i_req_wren[arb_idx];
                    mm_addr_d  = i_req_addr[arb_idx];
                    mm_wdata_d = i_req_wdata[arb_idx];
                    drop_d     = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (o_mm_rden && win_flush) begin
                    drop_d = 1'b1;
                end
                if (i_mm_gnt) begin
                    rr_d       = win_inc;
                    mm_rden_d  = 1'b0;
                    mm_wren_d  = 1'b0;
                    mm_addr_d  = '0;
                    mm_wdata_d = '0;
                    state_d    = o_mm_wren ? IDLE : WAIT_RD;
`ifdef NANOCACHE_SCHED_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            WAIT_RD: begin
                if (win_flush) begin
                    drop_d = 1'b1;
                end
                if (i_mm_rvalid) begin
                    resp_rdata_d = i_mm_rdata;
                    if (!(drop_q || win_flush)) begin
                        resp_valid_d = win_oh;
                    end
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef NANOCACHE_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            drop_q       <= 1'b0;
            o_mm_rden    <= 1'b0;
            o_mm_wren    <= 1'b0;
            o_mm_addr    <= '0;
            o_mm_wdata   <= '0;
            o_resp_valid <= '0;
            o_resp_rdata <= '0;
            o_busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            win_q        <= win_d;
            drop_q       <= drop_d;
            o_mm_rden    <= mm_rden_d;
            o_mm_wren    <= mm_wren_d;
            o_mm_addr    <= mm_addr_d;
            o_mm_wdata   <= mm_wdata_d;
            o_resp_valid <= resp_valid_d;
            o_resp_rdata <= resp_rdata_d;
            o_busy       <= (state_d != IDLE);
        end
    end

`ifdef NANOCACHE_SCHED_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            o_err <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            o_err <= err_d;
        end
    end
`else
    // Watchdog absent: never flags, TIMEOUT_CYC has no effect
    assign o_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule
